// File: rtl/r4_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// recoded digit encoding and the iteration count helper.
package r4_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Booth digit as magnitude select plus sign: one -> |X|, two -> 2|X|.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // One digit per multiplier bit pair, plus one extra digit so that
    // zero-extended unsigned operands recode exactly.
    function automatic int n_iter(input int dwidth);
        return dwidth / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: {y[2i+1], y[2i], y[2i-1]} -> {neg, one, two}.
module booth_r4_enc
    import r4_mul_pkg::*;
(
    input  logic [2:0] bits,
    output logic       neg,
    output logic       one,
    output logic       two
);

    booth_digit_t digit;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        digit = '0;
        case (bits)
            3'b001, 3'b010: digit.one = 1'b1;
            3'b011:         digit.two = 1'b1;
            3'b100:         begin digit.neg = 1'b1; digit.two = 1'b1; end
            3'b101, 3'b110: begin digit.neg = 1'b1; digit.one = 1'b1; end
            default:        digit = '0;
        endcase
    end

    assign neg = digit.neg;
    assign one = digit.one;
    assign two = digit.two;

endmodule

// File: rtl/r4_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both the operand and the product side.
module r4_booth_seq_mul
    import r4_mul_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int OWIDTH = 2 * DWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_signed,
    input  logic [DWIDTH-1:0] Xin,
    input  logic [DWIDTH-1:0] Yin,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [OWIDTH-1:0] Zout,
    output logic              busy
);

    localparam int N_ITER = n_iter(DWIDTH);
    localparam int CW     = $clog2(N_ITER + 1);
    localparam int HW     = DWIDTH + 3;   // accumulator upper half / partial product
    localparam int LW     = 2 * N_ITER;   // bits shifted out over the whole operation
    localparam int AW     = HW + LW;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DWIDTH:0]     x_reg;
    logic [DWIDTH+2:0]   y_reg;   // {extended Y, y[-1]}
    logic [AW-1:0]       acc;

    booth_digit_t        digit;
    logic [HW-1:0]       pp;
    logic [HW-1:0]       pp_add;
    logic [HW-1:0]       sum;
    logic [AW-1:0]       acc_next;

    booth_r4_enc u_enc (
        .bits (y_reg[2:0]),
        .neg  (digit.neg),
        .one  (digit.one),
        .two  (digit.two)
    );

    // Negative digits use one's complement with the +1 as adder carry-in.
    always_comb begin
        pp = '0;
        if (digit.two)
            pp = {x_reg[DWIDTH], x_reg, 1'b0};
        else if (digit.one)
            pp = {{2{x_reg[DWIDTH]}}, x_reg};
        pp_add   = digit.neg ? ~pp : pp;
        sum      = acc[AW-1:LW] + pp_add + HW'(digit.neg);
        acc_next = $signed({sum, acc[LW-1:0]}) >>> 2;
    end

    assign i_ready = (state == IDLE) && rstn;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every register samples the values from before this edge.
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            acc     <= '0;
            Zout    <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x_reg <= {i_signed & Xin[DWIDTH-1], Xin};
                        y_reg <= {{2{i_signed & Yin[DWIDTH-1]}}, Yin, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    y_reg <= {{2{y_reg[DWIDTH+2]}}, y_reg[DWIDTH+2:2]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N_ITER - 1)) begin
                        Zout    <= acc_next[OWIDTH-1:0];
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r4_booth_seq_mul.sv
// Scoreboard bench: three multiplier lanes (DWIDTH 4, 8, 16); directed cases
// on the 8-bit lane, then randomized traffic with random backpressure on all.
module tb_r4_booth_seq_mul;

    logic clk = 1'b0;
    logic rstn;

    logic [2:0]       i_valid_v, i_signed_v, o_ready_v;
    logic [2:0]       i_ready_v, o_valid_v, busy_v;
    logic [2:0][15:0] xin_p, yin_p;
    logic [2:0][31:0] zout_p;
    logic [2:0]       lane_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int W = 4 << g;
        logic [2*W-1:0] z;
        r4_booth_seq_mul #(.DWIDTH(W)) dut (
            .clk      (clk),
            .rstn     (rstn),
            .i_valid  (i_valid_v[g]),
            .i_ready  (i_ready_v[g]),
            .i_signed (i_signed_v[g]),
            .Xin      (xin_p[g][W-1:0]),
            .Yin      (yin_p[g][W-1:0]),
            .o_valid  (o_valid_v[g]),
            .o_ready  (o_ready_v[g]),
            .Zout     (z),
            .busy     (busy_v[g])
        );
        assign zout_p[g] = 32'(z);
    end

    // Reference: plain integer product of the operands as interpreted per mode.
    function automatic logic [31:0] ref_mul(int w, bit s, logic [15:0] x, logic [15:0] y);
        longint xv, yv, p;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic int qsize(int l);
        case (l)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push(int l, logic [31:0] v);
        case (l)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic logic [31:0] pop(int l);
        case (l)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: every output handshake pops one expected product.
    always @(negedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (rstn && o_valid_v[l] && o_ready_v[l]) begin
                if (qsize(l) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result w%0d: got 0x%0h, expected no output",
                             4 << l, zout_p[l]);
                end else begin
                    check($sformatf("zout_w%0d", 4 << l), zout_p[l], pop(l));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(int l, bit s, logic [15:0] x, logic [15:0] y, bit expect_result);
        int waited;
        waited = 0;
        i_valid_v[l]  = 1'b1;
        i_signed_v[l] = s;
        xin_p[l]      = x;
        yin_p[l]      = y;
        @(negedge clk);
        while (!i_ready_v[l] && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!i_ready_v[l]) timeout($sformatf("accept_w%0d", 4 << l));
        else if (expect_result) push(l, ref_mul(4 << l, s, x, y));
        @(posedge clk);
        #1;
        i_valid_v[l] = 1'b0;
    endtask

    task automatic drain(int l);
        int c;
        c = 0;
        while ((qsize(l) != 0 || busy_v[l]) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 1000) timeout($sformatf("drain_w%0d", 4 << l));
        @(posedge clk);
        #1;
    endtask

    task automatic run_lane(int l);
        int w;
        bit s;
        logic [15:0] mask, x, y;
        w    = 4 << l;
        mask = 16'((32'd1 << w) - 1);
        for (int n = 0; n < 120; n++) begin
            s = 1'($urandom_range(0, 1));
            x = 16'($urandom) & mask;
            y = 16'($urandom) & mask;
            case ($urandom_range(0, 7))
                0: x = mask;
                1: y = 16'(32'd1 << (w - 1));
                2: begin x = 16'(32'd1 << (w - 1)); y = mask; end
                default: ;
            endcase
            issue(l, s, x, y, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain(l);
        lane_done[l] = 1'b1;
    endtask

    task automatic toggle_ready(int l);
        while (!lane_done[l]) begin
            @(posedge clk);
            #1;
            o_ready_v[l] = ($urandom_range(0, 3) != 0);
        end
        o_ready_v[l] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        rstn       = 1'b0;
        i_valid_v  = '0;
        i_signed_v = '0;
        o_ready_v  = '1;
        xin_p      = '0;
        yin_p      = '0;
        lane_done  = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        @(negedge clk);
        check("reset_o_valid", o_valid_v[1], 0);
        check("reset_zout", zout_p[1], 0);
        check("reset_busy", busy_v[1], 0);
        check("reset_i_ready", i_ready_v[1], 1);
        @(posedge clk);
        #1;

        // 2 x 3 unsigned, with result latency measured from the accept edge.
        issue(1, 1'b0, 16'd2, 16'd3, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!o_valid_v[1] && lat < 30);
        check("latency_cycles", 32'(lat), 32'd5);
        @(posedge clk);
        #1;
        drain(1);

        issue(1, 1'b0, 16'hFF, 16'hFF, 1'b1); drain(1);
        issue(1, 1'b1, 16'hFF, 16'hFF, 1'b1); drain(1);
        issue(1, 1'b1, 16'h80, 16'h80, 1'b1); drain(1);
        issue(1, 1'b1, 16'h7F, 16'h80, 1'b1); drain(1);
        issue(1, 1'b1, 16'hFF, 16'h01, 1'b1); drain(1);

        // Backpressure: result must hold and new operands must be ignored.
        o_ready_v[1] = 1'b0;
        held = ref_mul(8, 1'b0, 16'h12, 16'h34);
        issue(1, 1'b0, 16'h12, 16'h34, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid_v[1] && lat < 30);
        if (!o_valid_v[1]) timeout("backpressure_o_valid");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            i_valid_v[1]  = 1'b1;
            i_signed_v[1] = 1'b0;
            xin_p[1]      = 16'h09;
            yin_p[1]      = 16'h09;
            @(negedge clk);
            check("hold_o_valid", o_valid_v[1], 1);
            check("hold_zout", zout_p[1], held);
            check("hold_i_ready", i_ready_v[1], 0);
        end
        @(posedge clk);
        #1;
        i_valid_v[1] = 1'b0;
        o_ready_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_i_ready", i_ready_v[1], 1);
        check("release_o_valid", o_valid_v[1], 0);
        check("release_zout_kept", zout_p[1], held);
        @(posedge clk);
        #1;
        drain(1);

        // Reset in the middle of an operation abandons it.
        issue(1, 1'b0, 16'h55, 16'h33, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_v[1], 0);
        check("abort_o_valid", o_valid_v[1], 0);
        check("abort_zout", zout_p[1], 0);
        check("abort_i_ready", i_ready_v[1], 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid_v[1]) seen++;
        end
        check("abort_no_valid", 32'(seen), 0);
        @(posedge clk);
        #1;
        issue(1, 1'b0, 16'd5, 16'd6, 1'b1);
        drain(1);

        // Randomized traffic on all lanes with random backpressure.
        for (int l = 0; l < 3; l++) begin
            automatic int ll = l;
            fork
                run_lane(ll);
                toggle_ready(ll);
            join_none
        end
        wait fork;

        for (int l = 0; l < 3; l++)
            check($sformatf("queue_empty_w%0d", 4 << l), 32'(qsize(l)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
